// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared sizes, the ROB entry record and a small pointer helper used by the
// reorder buffer and its read ports.
//   ROB_SIZE      number of ROB entries (power of two)
//   ROB_IDX_SIZE  width of a ROB index
//   ROB_CNT_SIZE  width of the occupancy counter (must hold ROB_SIZE itself)
//   GPR_SIZE      width of a general-purpose register value
//   GPR_IDX_SIZE  width of an architectural register index
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

   localparam int ROB_SIZE     = 8;
   localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
   localparam int ROB_CNT_SIZE = ROB_IDX_SIZE + 1;
   localparam int GPR_SIZE     = 32;
   localparam int GPR_IDX_SIZE = 4;

   // One in-flight instruction. valid marks an allocated slot, done marks
   // that its functional unit has written the result back.
   typedef struct packed {
      logic                    valid;
      logic                    done;
      logic                    mispred;
      logic                    set_nzcv;
      logic [GPR_IDX_SIZE-1:0] dst;
      logic [GPR_SIZE-1:0]     value;
      logic [3:0]              nzcv;
   } rob_entry_t;

   // Pointer increment; wraps naturally because ROB_SIZE is a power of two.
   function automatic logic [ROB_IDX_SIZE-1:0] robNext(input logic [ROB_IDX_SIZE-1:0] idx);
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/reorder_buffer_read_port.sv
// ---------------------------------------------------------------------------
// rob_read_port
// Combinational operand lookup into the ROB entry array for dispatch.
// A result being written back in the same cycle is forwarded directly so a
// dispatching instruction never misses a value that lands this cycle.
//   in_entries       full ROB entry array
//   in_rob_index     entry to look up
//   in_fu_done       FU writeback strobe (bypass source)
//   in_fu_rob_index  entry being written back
//   in_fu_value      value being written back
//   out_valid        looked-up entry holds a result
//   out_value        looked-up result
// ---------------------------------------------------------------------------
module rob_read_port
   import reorder_buffer_pkg::*;
(
   input  rob_entry_t [ROB_SIZE-1:0] in_entries,
   input  logic [ROB_IDX_SIZE-1:0]   in_rob_index,
   input  logic                      in_fu_done,
   input  logic [ROB_IDX_SIZE-1:0]   in_fu_rob_index,
   input  logic [GPR_SIZE-1:0]       in_fu_value,
   output logic                      out_valid,
   output logic [GPR_SIZE-1:0]       out_value
);

   // Stored result first, then let a matching same-cycle writeback override it.
   always_comb begin
      out_valid = in_entries[in_rob_index].valid & in_entries[in_rob_index].done;
      out_value = in_entries[in_rob_index].value;
      if (in_fu_done && (in_fu_rob_index == in_rob_index)) begin
         out_valid = 1'b1;
         out_value = in_fu_value;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer between dispatch and commit. Allocates an
// entry per dispatched instruction at the tail, captures FU results, re-
// broadcasts each result one cycle after writeback, serves operand lookups,
// and retires the head entry in program order. Committing a mispredicted
// branch flushes the whole buffer.
// Ports:
//   in_clk / in_rst_n            clock, synchronous active-low reset
//   in_alloc_*  / out_alloc_*    dispatch allocation request and response
//   in_src*_rob_index            dispatch operand lookup indices
//   out_src*_valid/value         operand lookup results
//   in_fu_*                      functional-unit writeback
//   out_broadcast_*              registered result broadcast (RS wakeup)
//   out_is_mispred               one-cycle flush pulse
//   out_commit_*                 head retirement to the register file / NZCV
// ---------------------------------------------------------------------------
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                    in_clk,
   input  logic                    in_rst_n,
   input  logic                    in_alloc_valid,
   input  logic [GPR_IDX_SIZE-1:0] in_alloc_dst,
   input  logic                    in_alloc_set_nzcv,
   output logic                    out_alloc_ready,
   output logic [ROB_IDX_SIZE-1:0] out_alloc_index,
   input  logic [ROB_IDX_SIZE-1:0] in_src1_rob_index,
   input  logic [ROB_IDX_SIZE-1:0] in_src2_rob_index,
   output logic                    out_src1_valid,
   output logic [GPR_SIZE-1:0]     out_src1_value,
   output logic                    out_src2_valid,
   output logic [GPR_SIZE-1:0]     out_src2_value,
   input  logic                    in_fu_done,
   input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
   input  logic [GPR_SIZE-1:0]     in_fu_value,
   input  logic [3:0]              in_fu_nzcv,
   input  logic                    in_fu_mispred,
   output logic                    out_broadcast_done,
   output logic [ROB_IDX_SIZE-1:0] out_broadcast_index,
   output logic [GPR_SIZE-1:0]     out_broadcast_val,
   output logic                    out_is_mispred,
   output logic                    out_commit_valid,
   output logic [GPR_IDX_SIZE-1:0] out_commit_dst,
   output logic [GPR_SIZE-1:0]     out_commit_value,
   output logic                    out_commit_set_nzcv,
   output logic [3:0]              out_commit_nzcv
);

   rob_entry_t [ROB_SIZE-1:0] r_entries;
   logic [ROB_IDX_SIZE-1:0]   r_head;
   logic [ROB_IDX_SIZE-1:0]   r_tail;
   logic [ROB_CNT_SIZE-1:0]   r_count;
   logic                      r_broadcast_done;
   logic [ROB_IDX_SIZE-1:0]   r_broadcast_index;
   logic [GPR_SIZE-1:0]       r_broadcast_val;
   logic                      r_is_mispred;

   rob_entry_t                w_head_entry;
   logic                      w_full;
   logic                      w_alloc_fire;
   logic                      w_commit_fire;
   logic                      w_wb_fire;
   logic                      w_flush;

   // Occupancy and handshake decode. Readiness depends only on the current
   // count, so a full buffer stalls allocation for a cycle even when the
   // head retires in that same cycle.
   assign w_head_entry  = r_entries[r_head];
   assign w_full        = (r_count == ROB_CNT_SIZE'(ROB_SIZE));
   assign w_alloc_fire  = in_alloc_valid & ~w_full;
   assign w_commit_fire = w_head_entry.valid & w_head_entry.done;
   assign w_wb_fire     = in_fu_done & r_entries[in_fu_rob_index].valid;
   assign w_flush       = w_commit_fire & w_head_entry.mispred;

   assign out_alloc_ready     = ~w_full;
   assign out_alloc_index     = r_tail;

   assign out_commit_valid    = w_commit_fire;
   assign out_commit_dst      = w_head_entry.dst;
   assign out_commit_value    = w_head_entry.value;
   assign out_commit_set_nzcv = w_head_entry.set_nzcv;
   assign out_commit_nzcv     = w_head_entry.nzcv;

   assign out_broadcast_done  = r_broadcast_done;
   assign out_broadcast_index = r_broadcast_index;
   assign out_broadcast_val   = r_broadcast_val;
   assign out_is_mispred      = r_is_mispred;

   // Two independent dispatch operand ports over the same entry array.
   rob_read_port u_src1_port (
      .in_entries      (r_entries),
      .in_rob_index    (in_src1_rob_index),
      .in_fu_done      (in_fu_done),
      .in_fu_rob_index (in_fu_rob_index),
      .in_fu_value     (in_fu_value),
      .out_valid       (out_src1_valid),
      .out_value       (out_src1_value)
   );

   rob_read_port u_src2_port (
      .in_entries      (r_entries),
      .in_rob_index    (in_src2_rob_index),
      .in_fu_done      (in_fu_done),
      .in_fu_rob_index (in_fu_rob_index),
      .in_fu_value     (in_fu_value),
      .out_valid       (out_src2_valid),
      .out_value       (out_src2_value)
   );

   // Main state update. Reset beats flush; a flush (committing a
   // mispredicted branch) wipes every entry and drops any alloc, writeback
   // or broadcast presented in that cycle. Otherwise writeback, alloc and
   // commit all act in the same cycle; commit clears the head last, and the
   // head and tail only coincide when the buffer is empty or full, where
   // commit or alloc respectively cannot fire.
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         r_entries         <= '0;
         r_head            <= '0;
         r_tail            <= '0;
         r_count           <= '0;
         r_broadcast_done  <= 1'b0;
         r_broadcast_index <= '0;
         r_broadcast_val   <= '0;
         r_is_mispred      <= 1'b0;
      end else if (w_flush) begin
         r_entries        <= '0;
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_broadcast_done <= 1'b0;
         r_is_mispred     <= 1'b1;
      end else begin
         r_is_mispred      <= 1'b0;
         r_broadcast_done  <= in_fu_done;
         r_broadcast_index <= in_fu_rob_index;
         r_broadcast_val   <= in_fu_value;

         if (w_wb_fire) begin
            r_entries[in_fu_rob_index].done    <= 1'b1;
            r_entries[in_fu_rob_index].value   <= in_fu_value;
            r_entries[in_fu_rob_index].nzcv    <= in_fu_nzcv;
            r_entries[in_fu_rob_index].mispred <= in_fu_mispred;
         end

         if (w_alloc_fire) begin
            r_entries[r_tail] <= '{valid:    1'b1,
                                   done:     1'b0,
                                   mispred:  1'b0,
                                   set_nzcv: in_alloc_set_nzcv,
                                   dst:      in_alloc_dst,
                                   value:    '0,
                                   nzcv:     '0};
            r_tail <= robNext(r_tail);
         end

         if (w_commit_fire) begin
            r_entries[r_head] <= '0;
            r_head            <= robNext(r_head);
         end

         unique case ({w_alloc_fire, w_commit_fire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
